rsa_operand_feeder: RTL and testbench
=====================================

Name: rsa_operand_feeder

Overview:
- Word-serial operand/result buffer sitting directly around the serial 32-bit add/sub stage.
- Holds two 1024-bit operands A and B (32 words x 32 bits), loaded by the host one word at a time.
- On command, streams words LSW-first to the add/sub stage and captures each result word into a result array for host readback.

Parameters:
- WORDS, 32, words per operand; must equal 32 to match the add/sub stage's 5-bit word counter.
- WIDTH, 32, bits per word.
- AW, 5, address width = log2(WORDS).

Ports:
- iClk  in  1  clock, rising edge.
- iRst  in  1  synchronous reset, active-high.
- iLoadEn  in  1  write iLoadData into the selected operand array this cycle.
- iLoadSel  in  1  0: operand A; 1: operand B.
- iLoadAddr  in  AW  word index, 0 = LSW.
- iLoadData  in  WIDTH  operand word.
- iGo  in  1  start an operation; sampled only in IDLE.
- iOp  in  1  0: add; 1: sub; latched on accepted iGo.
- iRdAddr  in  AW  result word index.
- oRdData  out  WIDTH  R[iRdAddr], registered, 1-cycle latency.
- oStart  out  1  1-cycle start pulse to the add/sub stage.
- oAddSub  out  1  latched op, held stable for the whole run.
- oA, oB  out  WIDTH  A[idx], B[idx], combinational from the word index.
- iDataShift  in  1  add/sub stage is consuming/producing a word this cycle.
- iD  in  WIDTH  add/sub result word.
- iDone  in  1  add/sub stage is on its last word.
- oBusy  out  1  high in START and RUN.
- oReady  out  1  1-cycle pulse when the result array is complete.
- oErr  out  1  sticky sequencing error; cleared by reset or by an accepted iGo.

Behaviour:
- Reset values: state IDLE, idx 0, oStart 0, oAddSub 0, oBusy 0, oReady 0, oErr 0, oRdData 0.
- The A, B and R arrays are not reset. Their contents are preserved across iRst.
- States:
  - IDLE: iGo=1 latches iOp into oAddSub, clears oErr, sets idx=0, goes to START.
  - START (1 cycle): oStart=1. The add/sub stage combines iStart into iDataShift, so iDataShift is expected high this cycle. Capture R[0]=iD, idx becomes 1, go to RUN.
  - RUN: each cycle with iDataShift=1, capture R[idx]=iD and increment idx. When iDataShift=1 and iDone=1, capture the last word and go to DONE.
  - DONE (1 cycle): oReady=1, then IDLE.
- Latency from accepted iGo to oReady: 33 cycles. iGo at cycle 0 gives START at 1, words captured at cycles 1..32, oReady at 33.
- Error conditions (oErr set, flow otherwise unchanged):
  - iDone=1 while idx!=WORDS-1.
  - idx==WORDS-1 captured without iDone.
  - iDataShift=0 in START or RUN. In this case no capture occurs and idx holds.
- If idx wraps from WORDS-1 to 0 without iDone, set oErr and return to IDLE. There is no oReady in this case.
- Loads: accepted only in IDLE. Loads while oBusy=1 are dropped and set oErr.
- Simultaneous iLoadEn and iGo in IDLE: the load is written and the run starts next cycle, so the run uses the new word.
- iGo while busy is ignored (no error).
- Reads are allowed at any time. Reading a word index during RUN returns the old value if that word has not yet been captured.
- Reset mid-operation: immediate IDLE, oStart/oBusy low next cycle. Any partial R contents remain.
- All widths are exact; no arithmetic is done here beyond the AW-bit idx increment.

Decomposition:
- Package rsa_pkg holds:
  - RSA_WORDS=32, RSA_WIDTH=32, RSA_AW=5.
  - State encoding IDLE/START/RUN/DONE.
  - OP_ADD=0, OP_SUB=1.
- One natural sub-module: rsa_word_regfile, a WORDS x WIDTH register array with one write port and one combinational read port.
  - Instantiated 3x: A, B and R.
  - R gets a registered read wrapper for oRdData.

Test Plan:
- Load A=all words 0xFFFFFFFF, B: word0=1 and all others 0; go with iOp=0, using the real add/sub stage -> R = all zeros, oReady at cycle 33, oErr=0.
- Load A: word0=5, others 0; B: word0=7, others 0; iOp=1 -> R[0]=0xFFFFFFFE and R[1..31]=0xFFFFFFFF; oAddSub stays 1 throughout.
- Model stage asserts iDone at idx=20 -> oErr=1 and the FSM completes. A second iGo clears oErr.
- iLoadEn to A[3] during RUN -> A[3] unchanged, oErr=1. A load of B[0] coincident with iGo in IDLE -> the new B[0] appears on oB at START.
- iRst asserted at idx=10 -> next cycle oBusy=0 and state IDLE. R[0..9] hold the new values and R[10..31] hold the old ones. A new iGo runs normally.
- Readback: iRdAddr=31 after DONE -> oRdData equals R[31] one cycle later. Changing iRdAddr every cycle gives a pipelined 1-cycle-latency stream.

Source files
------------

// File: rtl/rsa_pkg.sv
// Shared constants and state encoding for the RSA operand feeder slice.
package rsa_pkg;

   localparam int RSA_WORDS = 32;
   localparam int RSA_WIDTH = 32;
   localparam int RSA_AW    = 5;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_RUN   = 2'd2,
      ST_DONE  = 2'd3
   } rsaState_e;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   // Index of the most significant word of an operand.
   function automatic logic [RSA_AW-1:0] lastIdx();
      return RSA_AW'(RSA_WORDS - 1);
   endfunction

endpackage

// File: rtl/rsa_word_regfile.sv
// WORDS x WIDTH register array: one synchronous write port, one combinational read port.
// Contents are deliberately not reset so operands and results survive a reset.
module rsa_word_regfile
   import rsa_pkg::*;
#(
   parameter int WORDS = RSA_WORDS,
   parameter int WIDTH = RSA_WIDTH,
   parameter int AW    = RSA_AW
) (
   input  logic             iClk,
   input  logic             iWrEn,
   input  logic [AW-1:0]    iWrAddr,
   input  logic [WIDTH-1:0] iWrData,
   input  logic [AW-1:0]    iRdAddr,
   output logic [WIDTH-1:0] oRdData
);

   logic [WIDTH-1:0] mem [WORDS];

   // Write one word per cycle when enabled.
   always_ff @(posedge iClk) begin
      if (iWrEn) begin
         mem[iWrAddr] <= iWrData;
      end
   end

   assign oRdData = mem[iRdAddr];

endmodule

// File: rtl/rsa_operand_feeder.sv
// Word-serial operand/result buffer around the 32-bit add/sub stage.
// Streams A/B words LSW-first and captures each result word into R.
module rsa_operand_feeder
   import rsa_pkg::*;
#(
   parameter int WORDS = RSA_WORDS,
   parameter int WIDTH = RSA_WIDTH,
   parameter int AW    = RSA_AW
) (
   input  logic             iClk,
   input  logic             iRst,
   input  logic             iLoadEn,
   input  logic             iLoadSel,
   input  logic [AW-1:0]    iLoadAddr,
   input  logic [WIDTH-1:0] iLoadData,
   input  logic             iGo,
   input  logic             iOp,
   input  logic [AW-1:0]    iRdAddr,
   output logic [WIDTH-1:0] oRdData,
   output logic             oStart,
   output logic             oAddSub,
   output logic [WIDTH-1:0] oA,
   output logic [WIDTH-1:0] oB,
   input  logic             iDataShift,
   input  logic [WIDTH-1:0] iD,
   input  logic             iDone,
   output logic             oBusy,
   output logic             oReady,
   output logic             oErr
);

   localparam logic [AW-1:0] LAST_IDX = AW'(WORDS - 1);
   localparam logic [AW-1:0] IDX_ONE  = AW'(1);

   rsaState_e        state;
   logic [AW-1:0]    idx;
   logic             inRun;
   logic             loadOk;
   logic             aWrEn;
   logic             bWrEn;
   logic             rWrEn;
   logic             seqErr;
   logic [WIDTH-1:0] rRdComb;

   // Decode write enables and sequencing errors from the current state.
   always_comb begin
      inRun  = 1'b0;
      loadOk = 1'b0;
      seqErr = 1'b0;
      if ((state == ST_START) || (state == ST_RUN)) begin
         inRun = 1'b1;
      end else begin
         inRun = 1'b0;
      end
      if ((state == ST_IDLE) && iLoadEn && !iRst) begin
         loadOk = 1'b1;
      end else begin
         loadOk = 1'b0;
      end
      if (inRun) begin
         seqErr = iLoadEn
                | ~iDataShift
                | (iDataShift &  iDone & (idx != LAST_IDX))
                | (iDataShift & ~iDone & (idx == LAST_IDX));
      end else begin
         seqErr = 1'b0;
      end
      aWrEn = loadOk & (iLoadSel == 1'b0);
      bWrEn = loadOk & (iLoadSel == 1'b1);
      rWrEn = inRun & iDataShift & ~iRst;
   end

   rsa_word_regfile #(.WORDS(WORDS), .WIDTH(WIDTH), .AW(AW)) uA (
      .iClk    (iClk),
      .iWrEn   (aWrEn),
      .iWrAddr (iLoadAddr),
      .iWrData (iLoadData),
      .iRdAddr (idx),
      .oRdData (oA)
   );

   rsa_word_regfile #(.WORDS(WORDS), .WIDTH(WIDTH), .AW(AW)) uB (
      .iClk    (iClk),
      .iWrEn   (bWrEn),
      .iWrAddr (iLoadAddr),
      .iWrData (iLoadData),
      .iRdAddr (idx),
      .oRdData (oB)
   );

   rsa_word_regfile #(.WORDS(WORDS), .WIDTH(WIDTH), .AW(AW)) uR (
      .iClk    (iClk),
      .iWrEn   (rWrEn),
      .iWrAddr (idx),
      .iWrData (iD),
      .iRdAddr (iRdAddr),
      .oRdData (rRdComb)
   );

   // Host readback of the result array with one cycle of latency.
   always_ff @(posedge iClk) begin
      if (iRst) begin
         oRdData <= {WIDTH{1'b0}};
      end else begin
         oRdData <= rRdComb;
      end
   end

   // Sequencer: accepts iGo, walks idx through the words, flags sequencing errors.
   always_ff @(posedge iClk) begin
      if (iRst) begin
         state   <= ST_IDLE;
         idx     <= {AW{1'b0}};
         oStart  <= 1'b0;
         oAddSub <= 1'b0;
         oBusy   <= 1'b0;
         oReady  <= 1'b0;
         oErr    <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               oReady <= 1'b0;
               if (iGo) begin
                  oAddSub <= iOp;
                  oErr    <= 1'b0;
                  idx     <= {AW{1'b0}};
                  oStart  <= 1'b1;
                  oBusy   <= 1'b1;
                  state   <= ST_START;
               end
            end
            ST_START, ST_RUN: begin
               oStart <= 1'b0;
               if (seqErr) begin
                  oErr <= 1'b1;
               end
               if (iDataShift) begin
                  idx <= idx + IDX_ONE;
                  if (iDone) begin
                     oBusy  <= 1'b0;
                     oReady <= 1'b1;
                     state  <= ST_DONE;
                  end else if (idx == LAST_IDX) begin
                     // Wrapped past the last word without iDone: abandon the run.
                     oBusy <= 1'b0;
                     state <= ST_IDLE;
                  end else begin
                     state <= ST_RUN;
                  end
               end else begin
                  state <= ST_RUN;
               end
            end
            ST_DONE: begin
               oReady <= 1'b0;
               state  <= ST_IDLE;
            end
            default: begin
               state  <= ST_IDLE;
               oStart <= 1'b0;
               oBusy  <= 1'b0;
               oReady <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rsa_operand_feeder.sv
// Self-checking bench for rsa_operand_feeder with a word-serial add/sub stage model
// and a 1024-bit arithmetic reference for the expected result array.
module tb_rsa_operand_feeder;

   logic        iClk;
   logic        iRst;
   logic        iLoadEn;
   logic        iLoadSel;
   logic [4:0]  iLoadAddr;
   logic [31:0] iLoadData;
   logic        iGo;
   logic        iOp;
   logic [4:0]  iRdAddr;
   logic [31:0] oRdData;
   logic        oStart;
   logic        oAddSub;
   logic [31:0] oA;
   logic [31:0] oB;
   logic        iDataShift;
   logic [31:0] iD;
   logic        iDone;
   logic        oBusy;
   logic        oReady;
   logic        oErr;

   int checks   = 0;
   int failures = 0;

   logic [31:0] aMem [32];
   logic [31:0] bMem [32];
   logic [31:0] rMem [32];

   rsa_operand_feeder dut (
      .iClk       (iClk),
      .iRst       (iRst),
      .iLoadEn    (iLoadEn),
      .iLoadSel   (iLoadSel),
      .iLoadAddr  (iLoadAddr),
      .iLoadData  (iLoadData),
      .iGo        (iGo),
      .iOp        (iOp),
      .iRdAddr    (iRdAddr),
      .oRdData    (oRdData),
      .oStart     (oStart),
      .oAddSub    (oAddSub),
      .oA         (oA),
      .oB         (oB),
      .iDataShift (iDataShift),
      .iD         (iD),
      .iDone      (iDone),
      .oBusy      (oBusy),
      .oReady     (oReady),
      .oErr       (oErr)
   );

   initial begin
      iClk = 1'b0;
      forever #5 iClk = ~iClk;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic loadWord(input logic sel, input int addr, input logic [31:0] data);
      iLoadEn   = 1'b1;
      iLoadSel  = sel;
      iLoadAddr = 5'(addr);
      iLoadData = data;
      @(posedge iClk);
      @(negedge iClk);
      iLoadEn = 1'b0;
      if (sel == 1'b0) aMem[addr] = data;
      else             bMem[addr] = data;
   endtask

   task automatic loadRandom();
      for (int i = 0; i < 32; i++) begin
         loadWord(1'b0, i, $urandom);
         loadWord(1'b1, i, $urandom);
      end
   endtask

   // Pipelined readback: a new address each cycle, each word checked one cycle later.
   task automatic readBack(input string tag);
      int a;
      for (int k = 0; k < 36; k++) begin
         a = (k == 0) ? 31 : int'($urandom_range(0, 31));
         iRdAddr = 5'(a);
         @(posedge iClk);
         @(negedge iClk);
         check(tag, oRdData, rMem[a]);
      end
   endtask

   // One operation driven through a model of the serial add/sub stage.
   // doneAt: word on which iDone is raised (>31 means never); gapAt: word preceded
   // by one idle cycle (-1 none); rstAt: word at which reset hits (-1 none).
   task automatic runOp(input logic op, input int doneAt, input int gapAt, input int rstAt,
                        input bit loadMid, input bit coLoad);
      logic [1023:0] aBig, bBig, expBig;
      logic [32:0]   sum;
      logic [31:0]   opB;
      logic          carry;
      bit            gapDone, fin, expErr;
      int            w, cyc;
      if (coLoad) begin
         iLoadEn   = 1'b1;
         iLoadSel  = 1'b1;
         iLoadAddr = 5'd0;
         iLoadData = $urandom;
         bMem[0]   = iLoadData;
      end
      iGo = 1'b1;
      iOp = op;
      for (int i = 0; i < 32; i++) begin
         aBig[i*32 +: 32] = aMem[i];
         bBig[i*32 +: 32] = bMem[i];
      end
      expBig = (op == 1'b1) ? (aBig - bBig) : (aBig + bBig);
      expErr = (doneAt != 31) || loadMid || (gapAt >= 0);
      @(posedge iClk);
      @(negedge iClk);
      iGo     = 1'b0;
      iLoadEn = 1'b0;
      cyc = 1; w = 0; carry = op; gapDone = 0; fin = 0;
      check("start_pulse", {31'd0, oStart}, 32'd1);
      check("err_cleared", {31'd0, oErr}, 32'd0);
      while (!fin && cyc < 45) begin
         if (cyc > 1) check("start_low", {31'd0, oStart}, 32'd0);
         check("busy_run", {31'd0, oBusy}, 32'd1);
         check("addsub_held", {31'd0, oAddSub}, {31'd0, op});
         if (w == rstAt) begin
            iRst = 1'b1;
            @(posedge iClk);
            @(negedge iClk);
            iRst = 1'b0;
            check("rst_busy", {31'd0, oBusy}, 32'd0);
            check("rst_start", {31'd0, oStart}, 32'd0);
            check("rst_err", {31'd0, oErr}, 32'd0);
            return;
         end
         if (w == gapAt && !gapDone) begin
            iDataShift = 1'b0;
            iDone      = 1'b0;
            iD         = $urandom;
            gapDone    = 1;
         end else begin
            check("oA_word", oA, aMem[w]);
            check("oB_word", oB, bMem[w]);
            opB   = (op == 1'b1) ? ~oB : oB;
            sum   = {1'b0, oA} + {1'b0, opB} + {32'd0, carry};
            carry = sum[32];
            iD         = sum[31:0];
            iDataShift = 1'b1;
            iDone      = (w == doneAt);
            rMem[w]    = expBig[w*32 +: 32];
            if (w == doneAt || w == 31) fin = 1;
            w++;
         end
         if (loadMid && cyc == 6) begin
            iLoadEn   = 1'b1;
            iLoadSel  = 1'b0;
            iLoadAddr = 5'd3;
            iLoadData = ~aMem[3];
         end
         @(posedge iClk);
         @(negedge iClk);
         cyc++;
         iDataShift = 1'b0;
         iDone      = 1'b0;
         iLoadEn    = 1'b0;
      end
      if (doneAt <= 31) begin
         check("ready_pulse", {31'd0, oReady}, 32'd1);
         if (gapAt < 0 && doneAt == 31) check("latency", 32'(cyc), 32'd33);
      end else begin
         check("wrap_no_ready", {31'd0, oReady}, 32'd0);
      end
      check("busy_end", {31'd0, oBusy}, 32'd0);
      check("err_end", {31'd0, oErr}, {31'd0, expErr});
      @(posedge iClk);
      @(negedge iClk);
      check("ready_one_cycle", {31'd0, oReady}, 32'd0);
   endtask

   initial begin
      iRst = 1'b1; iLoadEn = 1'b0; iLoadSel = 1'b0; iLoadAddr = 5'd0; iLoadData = 32'd0;
      iGo = 1'b0; iOp = 1'b0; iRdAddr = 5'd0; iDataShift = 1'b0; iD = 32'd0; iDone = 1'b0;
      repeat (3) @(posedge iClk);
      @(negedge iClk);
      check("rst_oStart", {31'd0, oStart}, 32'd0);
      check("rst_oBusy", {31'd0, oBusy}, 32'd0);
      check("rst_oReady", {31'd0, oReady}, 32'd0);
      check("rst_oErr", {31'd0, oErr}, 32'd0);
      check("rst_oAddSub", {31'd0, oAddSub}, 32'd0);
      check("rst_oRdData", oRdData, 32'd0);
      iRst = 1'b0;
      @(negedge iClk);

      // All-ones plus one: every word wraps to zero through the carry chain.
      for (int i = 0; i < 32; i++) begin
         loadWord(1'b0, i, 32'hFFFF_FFFF);
         loadWord(1'b1, i, (i == 0) ? 32'd1 : 32'd0);
      end
      runOp(1'b0, 31, -1, -1, 0, 0);
      readBack("rd_add_wrap");
      check("add_r31_zero", rMem[31], 32'd0);

      // 5 - 7: borrow ripples through every word.
      for (int i = 0; i < 32; i++) begin
         loadWord(1'b0, i, (i == 0) ? 32'd5 : 32'd0);
         loadWord(1'b1, i, (i == 0) ? 32'd7 : 32'd0);
      end
      runOp(1'b1, 31, -1, -1, 0, 0);
      readBack("rd_sub_borrow");

      // Early iDone at word 20, then a clean run that clears the error.
      loadRandom();
      runOp(1'(($urandom) & 1), 20, -1, -1, 0, 0);
      readBack("rd_early_done");
      runOp(1'(($urandom) & 1), 31, -1, -1, 0, 0);
      readBack("rd_after_err");

      // Load of A[3] during the run is dropped; B[0] loaded alongside iGo is used.
      runOp(1'b0, 31, -1, -1, 1, 1);
      readBack("rd_coload");

      // Reset at word 10: R[0..9] updated, R[10..31] keep the previous run.
      loadRandom();
      runOp(1'b1, 31, -1, 10, 0, 0);
      readBack("rd_after_rst");
      runOp(1'b0, 31, -1, -1, 0, 0);
      readBack("rd_post_rst_run");

      // Stall cycle without iDataShift mid-run.
      runOp(1'(($urandom) & 1), 31, 7, -1, 0, 0);
      readBack("rd_gap");

      // Never raise iDone: idx wraps, run abandoned without oReady.
      loadRandom();
      runOp(1'b0, 99, -1, -1, 0, 0);
      readBack("rd_wrap");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
